// File: rtl/tree_router_input_port.sv
// Input stage of a NoC tree router: a small FIFO whose head entry is decoded
// into exactly one of three output channels (up / left / right).
module tree_router_input_port #(
  parameter int WIDTH_packet = 14,
  parameter int ADDR_W       = 4,
  parameter int LEVEL        = 1,
  parameter int NODE_PREFIX  = 0,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH_packet-1:0] in_data,
  output logic                    in_ready,
  output logic                    up_valid,
  output logic [WIDTH_packet-1:0] up_data,
  input  logic                    up_ready,
  output logic                    left_valid,
  output logic [WIDTH_packet-1:0] left_data,
  input  logic                    left_ready,
  output logic                    right_valid,
  output logic [WIDTH_packet-1:0] right_data,
  input  logic                    right_ready,
  output logic [15:0]             fwd_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUB_W = (LEVEL < ADDR_W) ? ADDR_W - LEVEL : 1;

  typedef enum logic [1:0] {ROUTE_UP, ROUTE_LEFT, ROUTE_RIGHT} route_t;

  logic [WIDTH_packet-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [PTR_W:0]          occ;
  logic                    full, empty, push, pop;
  logic [WIDTH_packet-1:0] head;
  logic [ADDR_W-1:0]       dest;
  logic                    in_subtree;
  route_t                  route;

  assign full     = (occ == (PTR_W+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;

  assign head = mem[rd_ptr];
  assign dest = head[WIDTH_packet-1 -: ADDR_W];

  // The root owns the whole address space, so it never forwards upward.
  generate
    if (LEVEL == ADDR_W) begin : g_root
      assign in_subtree = 1'b1;
    end else begin : g_inner
      localparam logic [SUB_W-1:0] PFX = SUB_W'(NODE_PREFIX);
      assign in_subtree = (dest[ADDR_W-1:LEVEL] == PFX);
    end
  endgenerate

  always_comb begin
    route = ROUTE_UP;
    if (in_subtree) route = dest[LEVEL-1] ? ROUTE_RIGHT : ROUTE_LEFT;
  end

  assign up_valid    = !empty && (route == ROUTE_UP);
  assign left_valid  = !empty && (route == ROUTE_LEFT);
  assign right_valid = !empty && (route == ROUTE_RIGHT);
  assign up_data     = head;
  assign left_data   = head;
  assign right_data  = head;

  assign pop = (up_valid && up_ready) || (left_valid && left_ready) ||
               (right_valid && right_ready);

  // Storage is deliberately left unreset; valids gate it while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      fwd_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        fwd_count <= fwd_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_router_input_port.sv
// Directed bench for tree_router_input_port: queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_tree_router_input_port;

  localparam int W = 14, AW = 4, LVL = 1, PFX = 2, D = 4;
  localparam int R_UP = 0, R_LEFT = 1, R_RIGHT = 2;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, in_ready;
  logic [W-1:0]  in_data = '0;
  logic          up_valid, left_valid, right_valid;
  logic [W-1:0]  up_data, left_data, right_data;
  logic          up_ready = 0, left_ready = 0, right_ready = 0;
  logic [15:0]   fwd_count;

  int compared = 0, mismatched = 0;

  tree_router_input_port #(
    .WIDTH_packet(W), .ADDR_W(AW), .LEVEL(LVL), .NODE_PREFIX(PFX), .DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .left_valid(left_valid), .left_data(left_data), .left_ready(left_ready),
    .right_valid(right_valid), .right_data(right_data), .right_ready(right_ready),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Routing straight from the address rules, on integers.
  function automatic int route_of(logic [W-1:0] p);
    int dest;
    dest = int'(p) >> (W - AW);
    if (LVL == AW || (dest >> LVL) == PFX)
      return ((dest >> (LVL - 1)) & 1) ? R_RIGHT : R_LEFT;
    return R_UP;
  endfunction

  // Reference model: ordered queue, forwarded count, push bookkeeping.
  logic [W-1:0] q[$];
  int           m_count = 0, n_push = 0;
  bit           last_push = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_count   = 0;
      n_push    = 0;
      last_push = 0;
    end else begin
      bit pu, po;
      int r;
      po = 0;
      if (q.size() > 0) begin
        r  = route_of(q[0]);
        po = (r == R_UP && up_ready) || (r == R_LEFT && left_ready) ||
             (r == R_RIGHT && right_ready);
      end
      pu = in_valid && (q.size() < D);
      if (po) begin
        void'(q.pop_front());
        m_count = (m_count + 1) % 65536;
      end
      if (pu) begin
        q.push_back(in_data);
        n_push++;
      end
      last_push = pu;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    int r;
    r = (q.size() > 0) ? route_of(q[0]) : -1;
    chk("in_ready", in_ready, q.size() < D);
    chk("up_valid", up_valid, r == R_UP);
    chk("left_valid", left_valid, r == R_LEFT);
    chk("right_valid", right_valid, r == R_RIGHT);
    chk("fwd_count", fwd_count, m_count);
    if (r == R_UP)    chk("up_data", up_data, q[0]);
    if (r == R_LEFT)  chk("left_data", left_data, q[0]);
    if (r == R_RIGHT) chk("right_data", right_data, q[0]);
  end

  task automatic send(input logic [W-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valids", {up_valid, left_valid, right_valid}, 0);
    chk("rst_fwd_count", fwd_count, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    bit done;
    do_reset();

    // Route decode with all channels ready.
    up_ready = 1; left_ready = 1; right_ready = 1;
    send(14'h1000);
    @(negedge clk);
    chk("lit_left_valid", left_valid, 1);
    chk("lit_left_data", left_data, 14'h1000);
    chk("lit_left_only", {up_valid, right_valid}, 0);
    @(posedge clk); #1;
    send(14'h1400);
    @(negedge clk);
    chk("lit_right_valid", right_valid, 1);
    chk("lit_right_data", right_data, 14'h1400);
    @(posedge clk); #1;
    send(14'h3C00);
    @(negedge clk);
    chk("lit_up_valid", up_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_count3", fwd_count, 3);

    // Reset mid-run with three packets buffered.
    @(posedge clk); #1;
    up_ready = 0; left_ready = 0; right_ready = 0;
    send(14'h3C01); send(14'h1000); send(14'h1400);
    @(negedge clk);
    chk("lit_buffered_up", up_valid, 1);
    #2;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      chk("lit_post_rst_valids", {up_valid, left_valid, right_valid}, 0);
    end
    @(posedge clk); #1;

    // Fill to full with up_ready low, then release one slot.
    for (int i = 0; i < 4; i++) send(14'h3C10 + 14'(i));
    in_valid = 1; in_data = 14'h3C14;
    @(negedge clk);
    chk("lit_full", in_ready, 0);
    chk("lit_full_head", up_data, 14'h3C10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_still_full", in_ready, 0);
    @(posedge clk); #1 up_ready = 1;
    @(posedge clk); #1 up_ready = 0;
    @(negedge clk);
    chk("lit_slot_free", in_ready, 1);
    chk("lit_second_head", up_data, 14'h3C11);
    @(posedge clk); #1 in_valid = 0; up_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_count5", fwd_count, 5);

    // Streaming at occupancy 2.
    @(posedge clk); #1 up_ready = 0;
    send(14'h3D00); send(14'h3D01);
    up_ready = 1; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 14'h3D02 + 14'(i);
      @(negedge clk);
      chk("lit_stream_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("lit_count25", fwd_count, 25);
    repeat (3) @(posedge clk);
    #1;

    // Head-of-line blocking: left head stalls a ready right packet.
    left_ready = 0; right_ready = 1;
    send(14'h1000); send(14'h1400);
    repeat (3) begin
      @(negedge clk);
      chk("lit_hol_right", right_valid, 0);
      chk("lit_hol_left", left_valid, 1);
      chk("lit_hol_count", fwd_count, 27);
      @(posedge clk); #1;
    end
    left_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_hol_right_now", right_valid, 1);
    chk("lit_hol_right_data", right_data, 14'h1400);
    chk("lit_hol_count28", fwd_count, 28);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_hol_count29", fwd_count, 29);

    // Counter wrap: 65537 random packets with mostly-high random readies.
    @(posedge clk); #1;
    do_reset();
    in_data = W'($urandom);
    done = 0;
    for (int cyc = 0; cyc < 90000 && !done; cyc++) begin
      in_valid    = 1;
      if (last_push) in_data = W'($urandom);
      up_ready    = ($urandom_range(31) != 0);
      left_ready  = ($urandom_range(31) != 0);
      right_ready = ($urandom_range(31) != 0);
      @(posedge clk); #1;
      done = (n_push >= 65537);
    end
    in_valid = 0;
    chk("wrap_push_budget", n_push, 65537);
    up_ready = 1; left_ready = 1; right_ready = 1;
    repeat (D + 2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_wrap_count", fwd_count, 1);
    chk("lit_wrap_empty", {up_valid, left_valid, right_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
